// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the boot-time UART program loader.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        LEN_LO = 3'd2,
        LEN_HI = 3'd3,
        DATA   = 3'd4,
        CSUM   = 3'd5,
        REPLY  = 3'd6
    } state_e;

    localparam logic [7:0] MAGIC_DEF = 8'hA5;
    localparam logic [7:0] ACK_DEF   = 8'h06;
    localparam logic [7:0] NAK_DEF   = 8'h15;

    function automatic logic [7:0] sum8_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/uart_loader_wordpack.sv
// Packs payload bytes little-endian into 32-bit words and registers the memory write.
module uart_loader_wordpack
    import uart_loader_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              cpu_clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              wr_allow,
    input  logic [7:0]        data,
    input  logic [ADDR_W-1:0] addr,
    output logic              word_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata
);

    logic [1:0]        idx_r;
    logic [23:0]       word_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic              word_done_s;

    // A word completes when its fourth byte is pushed.
    always_comb begin
        word_done_s = 1'b0;
        if (push && (idx_r == 2'd3)) begin
            word_done_s = 1'b1;
        end else begin
            word_done_s = 1'b0;
        end
    end

    // Byte shifter, byte index and one-cycle registered write strobe.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            idx_r       <= 2'd0;
            word_r      <= 24'd0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 32'd0;
        end else begin
            mem_we_r <= 1'b0;
            if (clr) begin
                idx_r  <= 2'd0;
                word_r <= 24'd0;
            end else if (push) begin
                case (idx_r)
                    2'd0: word_r[7:0]   <= data;
                    2'd1: word_r[15:8]  <= data;
                    2'd2: word_r[23:16] <= data;
                    2'd3: begin
                        // Words past the end of memory are dropped, never wrapped.
                        if (wr_allow) begin
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= addr;
                            mem_wdata_r <= {data, word_r};
                        end
                    end
                    default: idx_r <= 2'd0;
                endcase
                idx_r <= idx_r + 2'd1;
            end
        end
    end

    assign word_done = word_done_s;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: rtl/uart_loader.sv
// Frame parser for the boot loader: sync, length, payload, checksum and ACK/NAK reply.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int         ADDR_W = 12,
    parameter logic [7:0] MAGIC  = MAGIC_DEF,
    parameter logic [7:0] ACK    = ACK_DEF,
    parameter logic [7:0] NAK    = NAK_DEF
) (
    input  logic              cpu_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              r_ready,
    input  logic [7:0]        r_data_in,
    output logic              r_enable,
    input  logic              w_ready,
    output logic              w_enable,
    output logic [7:0]        w_data_out,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [17:0] DEPTH = 18'd1 << ADDR_W;

    state_e      state_r, state_s;
    logic [7:0]  len_lo_r;
    logic [17:0] bytes_left_r;
    logic [16:0] word_idx_r;
    logic [7:0]  sum_r;
    logic        ovf_r;
    logic [7:0]  reply_r;
    logic        error_r;
    logic        done_r;
    logic        pop_s;
    logic        magic_s;
    logic        push_s;
    logic        reply_push_s;
    logic        wr_allow_s;
    logic        nak_s;
    logic        word_done_s;

    // Pop qualification and per-cycle strobes derived from the current state.
    always_comb begin
        pop_s        = 1'b0;
        reply_push_s = 1'b0;
        case (state_r)
            SYNC, LEN_LO, LEN_HI, DATA, CSUM: pop_s = r_ready;
            REPLY:                            reply_push_s = w_ready;
            default: begin
                pop_s        = 1'b0;
                reply_push_s = 1'b0;
            end
        endcase
        magic_s    = (state_r == SYNC) && pop_s && (r_data_in == MAGIC);
        push_s     = (state_r == DATA) && pop_s;
        wr_allow_s = ({1'b0, word_idx_r} < DEPTH);
        nak_s      = (r_data_in != sum_r) || ovf_r;
    end

    // Next-state logic; every stalled state simply holds.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:   if (start) state_s = SYNC; else state_s = IDLE;
            SYNC:   if (magic_s) state_s = LEN_LO; else state_s = SYNC;
            LEN_LO: if (pop_s) state_s = LEN_HI; else state_s = LEN_LO;
            LEN_HI: begin
                if (pop_s) begin
                    if ({r_data_in, len_lo_r} == 16'd0) state_s = CSUM;
                    else state_s = DATA;
                end else begin
                    state_s = LEN_HI;
                end
            end
            DATA:   if (pop_s && (bytes_left_r == 18'd1)) state_s = CSUM; else state_s = DATA;
            CSUM:   if (pop_s) state_s = REPLY; else state_s = CSUM;
            REPLY:  if (w_ready) state_s = IDLE; else state_s = REPLY;
            default: state_s = IDLE;
        endcase
    end

    // Session registers: length, running sum, word index, overlength and reply.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state_r      <= IDLE;
            len_lo_r     <= 8'd0;
            bytes_left_r <= 18'd0;
            word_idx_r   <= 17'd0;
            sum_r        <= 8'd0;
            ovf_r        <= 1'b0;
            reply_r      <= 8'd0;
            error_r      <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= reply_push_s;
            case (state_r)
                IDLE: if (start) error_r <= 1'b0;
                SYNC: begin
                    if (magic_s) begin
                        sum_r      <= 8'd0;
                        ovf_r      <= 1'b0;
                        word_idx_r <= 17'd0;
                    end
                end
                LEN_LO: if (pop_s) len_lo_r <= r_data_in;
                LEN_HI: if (pop_s) bytes_left_r <= {r_data_in, len_lo_r, 2'b00};
                DATA: begin
                    if (pop_s) begin
                        bytes_left_r <= bytes_left_r - 18'd1;
                        sum_r        <= sum8_add(sum_r, r_data_in);
                        if (word_done_s) begin
                            word_idx_r <= word_idx_r + 17'd1;
                            if (!wr_allow_s) ovf_r <= 1'b1;
                        end
                    end
                end
                CSUM: begin
                    if (pop_s) begin
                        reply_r <= nak_s ? NAK : ACK;
                        error_r <= nak_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    uart_loader_wordpack #(
        .ADDR_W (ADDR_W)
    ) u_wordpack (
        .cpu_clk   (cpu_clk),
        .rst       (rst),
        .clr       (magic_s),
        .push      (push_s),
        .wr_allow  (wr_allow_s),
        .data      (r_data_in),
        .addr      (word_idx_r[ADDR_W-1:0]),
        .word_done (word_done_s),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    assign r_enable   = pop_s;
    assign w_enable   = reply_push_s;
    assign w_data_out = reply_r;
    assign busy       = (state_r != IDLE);
    assign done       = done_r;
    assign error      = error_r;

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: FIFO model feeds frames, expected writes/replies are queued.
module tb_uart_loader;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              cpu_clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              r_ready = 1'b0;
    logic [7:0]        r_data_in = 8'd0;
    logic              r_enable;
    logic              w_ready = 1'b1;
    logic              w_enable;
    logic [7:0]        w_data_out;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  rx_q[$];
    logic [43:0] wq[$];
    logic [7:0]  rq[$];
    logic [31:0] words_q[$];
    logic        pop_pend = 1'b0;
    int          gap = 0;
    int          stall_cnt = 0;
    logic        exp_err = 1'b0;

    uart_loader #(.ADDR_W(ADDR_W)) dut (
        .cpu_clk    (cpu_clk),
        .rst        (rst),
        .start      (start),
        .r_ready    (r_ready),
        .r_data_in  (r_data_in),
        .r_enable   (r_enable),
        .w_ready    (w_ready),
        .w_enable   (w_enable),
        .w_data_out (w_data_out),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Receive FIFO model: consumes a byte when popped, optionally spaces bytes apart.
    initial begin
        forever begin
            @(posedge cpu_clk);
            #1;
            if (pop_pend && rx_q.size() > 0) begin
                void'(rx_q.pop_front());
                stall_cnt = gap;
            end else if (stall_cnt > 0) begin
                stall_cnt--;
            end
            r_ready   = (rx_q.size() > 0) && (stall_cnt == 0);
            r_data_in = r_ready ? rx_q[0] : 8'd0;
        end
    end

    // Output monitor: compares memory writes and replies against the scoreboard.
    initial begin
        forever begin
            @(negedge cpu_clk);
            pop_pend = r_enable;
            if (mem_we) begin
                check("we_expected", (wq.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                if (wq.size() != 0) begin
                    logic [43:0] e;
                    e = wq.pop_front();
                    check("we_addr", {20'd0, mem_addr}, {20'd0, e[43:32]});
                    check("we_data", mem_wdata, e[31:0]);
                end
            end
            if (w_enable) begin
                check("reply_expected", (rq.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                if (rq.size() != 0) begin
                    logic [7:0] r;
                    r = rq.pop_front();
                    check("reply_byte", {24'd0, w_data_out}, {24'd0, r});
                end
            end
            if (done) check("busy_low_on_done", {31'd0, busy}, 32'd0);
        end
    end

    // Frames words_q and queues the expected writes, reply and error state.
    task automatic build_frame(input bit use_csum, input logic [7:0] csum_val);
        logic [7:0] sum;
        logic [7:0] b;
        logic [7:0] csum;
        logic [15:0] len;
        bit nak;
        len = 16'(words_q.size());
        sum = 8'd0;
        rx_q.push_back(8'hA5);
        rx_q.push_back(len[7:0]);
        rx_q.push_back(len[15:8]);
        for (int i = 0; i < words_q.size(); i++) begin
            for (int k = 0; k < 4; k++) begin
                b = words_q[i][8*k +: 8];
                rx_q.push_back(b);
                sum = sum + b;
            end
            if (i < DEPTH) wq.push_back({12'(i), words_q[i]});
        end
        csum = use_csum ? csum_val : sum;
        rx_q.push_back(csum);
        nak = (csum != sum) || (int'(len) > DEPTH);
        rq.push_back(nak ? 8'h15 : 8'h06);
        exp_err = nak;
        words_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge cpu_clk);
        #1 start = 1'b1;
        @(posedge cpu_clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge cpu_clk);
            n++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        check({tag, "_wq_drained"}, wq.size(), 32'd0);
        check({tag, "_rq_drained"}, rq.size(), 32'd0);
        @(negedge cpu_clk);
        check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    task automatic wait_rx_empty(input string tag, input int budget);
        int n;
        n = 0;
        while ((rx_q.size() != 0) && n < budget) begin
            @(negedge cpu_clk);
            n++;
        end
        check({tag, "_rx_empty"}, rx_q.size(), 32'd0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge cpu_clk);
        check("rst_r_enable", {31'd0, r_enable}, 32'd0);
        check("rst_w_enable", {31'd0, w_enable}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_w_data", {24'd0, w_data_out}, 32'd0);
        check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge cpu_clk);
        #1 rst = 1'b0;

        // Single word, good checksum
        words_q.push_back(32'h12345678);
        build_frame(1'b0, 8'd0);
        pulse_start();
        @(negedge cpu_clk);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        wait_done("t1", 100);

        // Same frame with a bad checksum: write still happens, NAK, sticky error
        words_q.push_back(32'h12345678);
        build_frame(1'b1, 8'h00);
        pulse_start();
        wait_done("t2", 100);
        repeat (5) @(negedge cpu_clk);
        check("t2_error_sticky", {31'd0, error}, 32'd1);

        // Garbage before MAGIC is discarded, LEN=0 frame ACKs; start clears error
        rx_q.push_back(8'h00);
        rx_q.push_back(8'hFF);
        rx_q.push_back(8'h3C);
        build_frame(1'b0, 8'd0);
        pulse_start();
        @(negedge cpu_clk);
        check("t3_error_cleared", {31'd0, error}, 32'd0);
        wait_done("t3", 100);

        // Transmit FIFO full on entering REPLY
        w_ready = 1'b0;
        build_frame(1'b0, 8'd0);
        pulse_start();
        wait_rx_empty("t4", 100);
        repeat (10) begin
            @(negedge cpu_clk);
            check("t4_wen_held", {31'd0, w_enable}, 32'd0);
        end
        check("t4_busy_in_reply", {31'd0, busy}, 32'd1);
        @(posedge cpu_clk);
        #1 w_ready = 1'b1;
        @(negedge cpu_clk);
        check("t4_wen_on_ready", {31'd0, w_enable}, 32'd1);
        @(negedge cpu_clk);
        check("t4_done_next", {31'd0, done}, 32'd1);
        check("t4_wen_once", {31'd0, w_enable}, 32'd0);

        // Reset mid-payload, then a full two-word frame
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'h02);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        pulse_start();
        wait_rx_empty("t5a", 100);
        repeat (2) @(negedge cpu_clk);
        @(posedge cpu_clk);
        #1 rst = 1'b1;
        @(posedge cpu_clk);
        #1 rst = 1'b0;
        @(negedge cpu_clk);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_r_enable", {31'd0, r_enable}, 32'd0);
        check("t5_rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        check("t5_rst_mem_wdata", mem_wdata, 32'd0);
        check("t5_rst_w_data", {24'd0, w_data_out}, 32'd0);
        words_q.push_back(32'hA1B2C3D4);
        words_q.push_back(32'h0BADF00D);
        build_frame(1'b0, 8'd0);
        pulse_start();
        wait_done("t5", 100);

        // Slow link: bytes 870 cycles apart, three words
        gap = 870;
        for (int i = 0; i < 3; i++) words_q.push_back(32'hCAFE0000 ^ (32'(i) * 32'h9E3779B1));
        build_frame(1'b0, 8'd0);
        pulse_start();
        wait_done("t6", 20000);
        gap = 0;

        // Overlength: one word past the end of memory is dropped and NAKed
        for (int i = 0; i < DEPTH + 1; i++) words_q.push_back(32'(i) * 32'h01000193 + 32'h5A);
        build_frame(1'b0, 8'd0);
        pulse_start();
        wait_done("t7", 20000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
# uart_loader

Boot-time program loader on the consumer side of the `uart` FIFO ports. On `start` it pops a framed image from the receive FIFO, packs bytes into 32-bit little-endian words, and writes them sequentially into instruction memory. After validating a checksum it pushes a one-byte ACK/NAK reply into the transmit FIFO. It holds the CPU (`busy`) for the whole session and sits between `uart` and the instruction-memory write port.

## Interface
Parameters:
- `ADDR_W`, 12: instruction-memory word-address width; depth = 2**ADDR_W words.
- `MAGIC`, 8'hA5: frame sync byte.
- `ACK`, 8'h06: reply byte on checksum match.
- `NAK`, 8'h15: reply byte on checksum mismatch or overlength.

Ports:
- `cpu_clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin session; sampled only in IDLE.
- `r_ready` in 1: receive FIFO non-empty.
- `r_data_in` in 8: receive FIFO head byte, valid combinationally while `r_ready`.
- `r_enable` out 1: pop; byte consumed in the same cycle.
- `w_ready` in 1: transmit FIFO not full.
- `w_enable` out 1: push `w_data_out`.
- `w_data_out` out 8: reply byte.
- `mem_we` out 1: word write strobe.
- `mem_addr` out ADDR_W: word address.
- `mem_wdata` out 32: word data.
- `busy` out 1: session active; CPU held.
- `done` out 1: one-cycle end-of-session pulse.
- `error` out 1: sticky; last session NAKed; cleared on next accepted `start`.

## Operation
- Frame: MAGIC, LEN_LO, LEN_HI (16-bit word count), LEN×4 payload bytes (word LSB first), CSUM = 8-bit sum mod 256 of all payload bytes.
- States: IDLE → SYNC on `start`. In SYNC, non-MAGIC bytes are popped and discarded; MAGIC moves to LEN_LO. Then LEN_LO → LEN_HI → DATA, or → CSUM when LEN==0. DATA → CSUM after the 4·LEN-th byte. CSUM → REPLY. REPLY → IDLE after the push.
- `r_enable` = `r_ready` AND state ∈ {SYNC, LEN_LO, LEN_HI, DATA, CSUM}. Pops at most one byte per cycle and never pops in IDLE or REPLY.
- The word packer shifts each byte into position by byte index 0..3. Each 4th byte completes a word at `mem_addr`, and the address then increments starting from 0.
- Running sum is 8-bit and wraps. It is cleared when MAGIC is accepted.
- LEN > 2**ADDR_W: words at index ≥ 2**ADDR_W are not written (no `mem_we`, no address wrap), bytes are still consumed and summed, and the reply is NAK.
- Reply is NAK if the sum differs from CSUM or on overlength, otherwise ACK. `error` is set on NAK.
- `start` while not IDLE is ignored.
- `rst` mid-session: immediate return to IDLE with all outputs cleared. Memory words already written remain. The host must resend the full frame.

## Timing
- Reset values: `r_enable`, `w_enable`, `mem_we`, `busy`, `done`, `error` = 0; `w_data_out`, `mem_addr`, `mem_wdata` = 0.
- `busy` rises the cycle after `start` is accepted and falls in the cycle `done` is high.
- `mem_we` is registered: it is high for exactly one cycle, the cycle after the 4th byte of a word is popped, with `mem_addr`/`mem_wdata` valid in that same cycle.
- REPLY: `w_enable` is high for exactly one cycle, the first REPLY cycle with `w_ready`=1. While `w_ready`=0 it stays low and REPLY is held indefinitely.
- `done` pulses the cycle after the `w_enable` cycle, with the state back in IDLE.
- Throughput: one byte per cycle when the FIFO stays non-empty. Gaps in `r_ready` stall the state machine without losing state.

## Structure
- Shared package `uart_loader_pkg`: state enum (IDLE, SYNC, LEN_LO, LEN_HI, DATA, CSUM, REPLY), and default MAGIC/ACK/NAK constants.
- One sub-module, `uart_loader_wordpack`: byte-to-word shifter, 2-bit byte index, and registered `mem_we`/`mem_wdata` output. The top level holds the state machine, length counter, sum, and reply logic.

## Test plan
- `start`, FIFO holds A5 01 00 78 56 34 12 14 → single `mem_we`, addr 0, data 32'h12345678; `w_data_out`=8'h06; `done` pulse; `error`=0.
- Same frame with CSUM 00 → write still occurs; reply 8'h15; `error`=1 until the next `start`.
- FIFO holds 00 FF 3C A5 00 00 00 → three bytes discarded, no `mem_we`, reply 06.
- `w_ready` held 0 for 10 cycles on entering REPLY → `w_enable` stays 0, then pulses once in the cycle `w_ready` rises; `done` follows one cycle later.
- `rst` after two payload bytes → all outputs 0 next cycle. A following full frame (LEN=2) writes addr 0 then 1 correctly.
- Bytes arriving 870 cycles apart via a real `uart` RX, LEN=3 → three writes at addr 0,1,2, correct data, ACK.
